// File: rtl/cpu_clk_ctrl.sv
// Run-control sequencer: emits a single-cycle CPU advance enable for run, step and halt modes.
// Latency: CPU_clk_en is registered; it asserts the cycle after the deciding edge.
// Backpressure: none; Halt holds the sequencer in PAUSE and suppresses all pulses.
module cpu_clk_ctrl #(
   parameter int DIV0       = 50000,
   parameter int DIV1       = 500000,
   parameter int DIV2       = 5000000,
   parameter int DIV3       = 50000000,
   parameter int DEB_CYCLES = 1000000,
   parameter int CNT_W      = 16
) (
   input  logic             CLK_100mhz,
   input  logic             Reset,
   input  logic             Run_sw,
   input  logic             Step_btn,
   input  logic [1:0]       Div_sel,
   input  logic             Halt,
   output logic             CPU_clk_en,
   output logic             Running,
   output logic [CNT_W-1:0] Cycle_count
);

   // Divider counter only ever reaches N-1, so size it for the largest period.
   localparam int DIV_MAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
   localparam int DIV_MAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
   localparam int DIV_MAX   = (DIV_MAX01 > DIV_MAX23) ? DIV_MAX01 : DIV_MAX23;
   localparam int CW        = $clog2(DIV_MAX);
   localparam int DW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   localparam logic [CW-1:0] LAST0    = CW'(DIV0 - 1);
   localparam logic [CW-1:0] LAST1    = CW'(DIV1 - 1);
   localparam logic [CW-1:0] LAST2    = CW'(DIV2 - 1);
   localparam logic [CW-1:0] LAST3    = CW'(DIV3 - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {PAUSE, RUN, STEP, HOLD} state_t;

   state_t          state, state_nxt;
   logic            pulse_nxt;
   logic            run_s1, run_s2, btn_s1, btn_s2;
   logic            btn_lvl;
   logic [DW-1:0]   deb_cnt;
   logic            deb_diff, deb_done, step_req;
   logic [1:0]      div_sel_r;
   logic [CW-1:0]   div_cnt, div_last;
   logic            div_chg, tick;

   // Two-flop synchronisers for the asynchronous switch and button.
   always_ff @(posedge CLK_100mhz) begin
      if (!Reset) begin
         run_s1 <= 1'b0;
         run_s2 <= 1'b0;
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         run_s1 <= Run_sw;
         run_s2 <= run_s1;
         btn_s1 <= Step_btn;
         btn_s2 <= btn_s1;
      end
   end

   // The sample that completes DEB_CYCLES differing samples is the one that flips the level.
   assign deb_diff = (btn_s2 != btn_lvl);
   assign deb_done = deb_diff && (deb_cnt == DEB_LAST);
   assign step_req = deb_done && btn_s2;

   // Debounce: count consecutive differing samples, accept the new level when they reach the limit.
   always_ff @(posedge CLK_100mhz) begin
      if (!Reset) begin
         deb_cnt <= '0;
         btn_lvl <= 1'b0;
      end else if (!deb_diff) begin
         deb_cnt <= '0;
      end else if (deb_done) begin
         deb_cnt <= '0;
         btn_lvl <= btn_s2;
      end else begin
         deb_cnt <= deb_cnt + DW'(1);
      end
   end

   // Terminal count for the currently registered rate.
   always_comb begin
      div_last = LAST0;
      case (div_sel_r)
         2'd0:    div_last = LAST0;
         2'd1:    div_last = LAST1;
         2'd2:    div_last = LAST2;
         default: div_last = LAST3;
      endcase
   end

   // A rate change restarts the period from zero without ticking, so no short pulse can escape.
   assign div_chg = (div_sel_r != Div_sel);
   assign tick    = (state == RUN) && !div_chg && (div_cnt == div_last);

   // Rate divider: advances only in RUN, wraps on tick, restarts on a rate change.
   always_ff @(posedge CLK_100mhz) begin
      if (!Reset) begin
         div_sel_r <= 2'd0;
         div_cnt   <= '0;
      end else begin
         div_sel_r <= Div_sel;
         if ((state != RUN) || div_chg || tick)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + CW'(1);
      end
   end

   // Next-state and pulse decision; Halt wins over the switch, the switch wins over a step press.
   always_comb begin
      state_nxt = state;
      pulse_nxt = 1'b0;
      case (state)
         PAUSE: begin
            if (run_s2 && !Halt)
               state_nxt = RUN;
            else if (step_req && !Halt)
               state_nxt = STEP;
         end
         RUN: begin
            if (Halt || !run_s2)
               state_nxt = PAUSE;
            else
               pulse_nxt = tick;
         end
         STEP: begin
            pulse_nxt = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (!btn_lvl)
               state_nxt = PAUSE;
         end
         default: state_nxt = PAUSE;
      endcase
   end

   // State register and registered outputs; Running tracks the state being entered.
   always_ff @(posedge CLK_100mhz) begin
      if (!Reset) begin
         state       <= PAUSE;
         CPU_clk_en  <= 1'b0;
         Running     <= 1'b0;
         Cycle_count <= '0;
      end else begin
         state      <= state_nxt;
         CPU_clk_en <= pulse_nxt;
         Running    <= (state_nxt == RUN);
         if (pulse_nxt)
            Cycle_count <= Cycle_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with a pulse scoreboard.
// Latency: expected pulses are queued with their absolute clock edge and checked on arrival.
// Backpressure: not applicable; all waits are bounded by cycle targets and a watchdog.
module tb_cpu_clk_ctrl;

   logic       clk;
   logic       Reset;
   logic       Run_sw;
   logic       Step_btn;
   logic [1:0] Div_sel;
   logic       Halt;
   logic       CPU_clk_en;
   logic       Running;
   logic [3:0] Cycle_count;

   typedef struct {
      int         cyc;
      logic [3:0] cnt;
   } exp_t;

   exp_t       q[$];
   int         tests = 0;
   int         fails = 0;
   int         cyc   = 0;
   logic [3:0] mcnt;
   exp_t       mon_e;
   logic       mon_exp;

   cpu_clk_ctrl #(
      .DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10), .DEB_CYCLES(3), .CNT_W(4)
   ) dut (
      .CLK_100mhz (clk),
      .Reset      (Reset),
      .Run_sw     (Run_sw),
      .Step_btn   (Step_btn),
      .Div_sel    (Div_sel),
      .Halt       (Halt),
      .CPU_clk_en (CPU_clk_en),
      .Running    (Running),
      .Cycle_count(Cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge index: value of cyc seen at a falling edge is the number of rising edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int at);
      mcnt = mcnt + 4'd1;
      q.push_back('{cyc: at, cnt: mcnt});
   endtask

   task automatic step_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Scoreboard monitor: every pulse must match the head of the queue in time and count.
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
         chk("pulse_missed_at", cyc, q[0].cyc);
         void'(q.pop_front());
      end
      mon_exp = (q.size() > 0) && (q[0].cyc == cyc);
      if (CPU_clk_en === 1'b1 || mon_exp) begin
         chk("pulse_en", CPU_clk_en, mon_exp);
         if (mon_exp) begin
            mon_e = q.pop_front();
            chk("pulse_count", Cycle_count, mon_e.cnt);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      Reset = 1'b0; Run_sw = 1'b0; Step_btn = 1'b0; Div_sel = 2'd0; Halt = 1'b0;
      mcnt = 4'd0;

      // Reset state
      step_n(3);
      chk("rst_en", CPU_clk_en, 0);
      chk("rst_running", Running, 0);
      chk("rst_count", Cycle_count, 0);
      Reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step_n(10);
         chk("idle_running", Running, 0);
         chk("idle_count", Cycle_count, 0);
      end

      // Continuous run at DIV0=4: RUN entered 3 edges after the switch, pulses every 4
      c = cyc;
      Run_sw = 1'b1;
      for (int i = 0; i < 16; i++) push(c + 3 + 4 * (i + 1));
      step_n(3);
      chk("run_running", Running, 1);
      wait_cyc(c + 68);
      chk("run_q_empty", q.size(), 0);
      chk("wrap_count", Cycle_count, 0);

      // Rate switch midway: pending pulse dropped, next one 10 edges after registration
      c = cyc;
      Div_sel = 2'd3;
      push(c + 11);
      push(c + 21);
      push(c + 31);
      wait_cyc(c + 33);
      chk("div_q_empty", q.size(), 0);
      chk("div_count", Cycle_count, mcnt);

      // Leave RUN
      Run_sw = 1'b0;
      step_n(4);
      chk("pause_running", Running, 0);
      step_n(3);

      // Short glitch is rejected by the debouncer
      Step_btn = 1'b1;
      step_n(2);
      Step_btn = 1'b0;
      step_n(10);
      chk("glitch_count", Cycle_count, mcnt);

      // Clean press: one pulse 6 edges after the press, none while held
      for (int p = 0; p < 2; p++) begin
         c = cyc;
         Step_btn = 1'b1;
         push(c + 6);
         step_n(20);
         Step_btn = 1'b0;
         step_n(10);
         chk("step_q_empty", q.size(), 0);
         chk("step_count", Cycle_count, mcnt);
      end

      // Halt on the tick cycle of RUN
      c = cyc;
      Run_sw = 1'b1;
      push(c + 13);
      wait_cyc(c + 22);
      Halt = 1'b1;
      step_n(2);
      chk("halt_running", Running, 0);
      chk("halt_q_empty", q.size(), 0);
      chk("halt_count", Cycle_count, mcnt);
      step_n(5);
      chk("halt_hold_running", Running, 0);

      // Step press while halted gives nothing
      Run_sw = 1'b0;
      step_n(5);
      Step_btn = 1'b1;
      step_n(20);
      Step_btn = 1'b0;
      step_n(10);
      chk("halt_step_count", Cycle_count, mcnt);

      // Resume
      Halt = 1'b0;
      c = cyc;
      Run_sw = 1'b1;
      push(c + 13);
      step_n(4);
      chk("resume_running", Running, 1);
      wait_cyc(c + 14);
      chk("resume_q_empty", q.size(), 0);
      chk("resume_count", Cycle_count, mcnt);
      Run_sw = 1'b0;
      step_n(6);
      chk("stop_running", Running, 0);

      // Reset while in STEP drops the pending pulse
      c = cyc;
      Step_btn = 1'b1;
      wait_cyc(c + 5);
      Reset = 1'b0;
      Step_btn = 1'b0;
      step_n(1);
      chk("rst_step_en", CPU_clk_en, 0);
      chk("rst_step_count", Cycle_count, 0);
      chk("rst_step_running", Running, 0);
      mcnt = 4'd0;
      step_n(2);
      Reset = 1'b1;
      step_n(30);
      chk("post_rst_count", Cycle_count, 0);
      chk("post_rst_en", CPU_clk_en, 0);
      chk("post_rst_q_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
